demux_dispatch_x4: RTL and testbench
====================================

Name: demux_dispatch_x4

Overview:
Upstream feeder for demux_nbit_x4. Accepts a valid/ready word stream, buffers words in a small FIFO, and presents one word at a time as y/sel to the 1-to-4 demux. Raises a one-hot lane strobe and holds the word until the addressed lane accepts it. Destination comes from a per-word tag or from an internal round-robin counter.

Parameters:
BUS_WIDTH, 8, data width; must match the demux BUS_WIDTH.
FIFO_DEPTH, 4, buffer entries; power of 2, at least 2.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous clear of the FIFO and output stage.
rr_mode  input  1  1 = ignore in_dest and use round-robin lane; 0 = use in_dest.
in_data  input  BUS_WIDTH  incoming word.
in_dest  input  2  destination lane, 0=a, 1=b, 2=c, 3=d.
in_valid  input  1  in_data/in_dest valid.
in_ready  output  1  block can accept a word this cycle.
y  output  BUS_WIDTH  word to the demux y input.
sel  output  2  lane select to the demux sel input.
lane_valid  output  4  one-hot strobe; bit k marks the word on demux output k as valid.
lane_ready  input  4  per-lane accept from downstream consumers.
level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy, excluding the output stage.

Behaviour:
- Reset (rst_n=0, async), with the same effect from flush=1 at the next edge:
  - FIFO empty: pointers 0, level 0.
  - Output stage empty.
  - Outputs: y=0, sel=0, lane_valid=0.
  - Round-robin counter = 0.
  - in_ready is held 0 while rst_n=0.
- Accept: happens when in_valid && in_ready.
  - in_ready = !full. There is no same-cycle bypass: a full FIFO stays not-ready even if a pop occurs in the same cycle.
  - Stored tag = rr_mode ? rr_cnt : in_dest.
  - rr_cnt increments mod 4 only on accepts made with rr_mode=1. Its value persists when rr_mode toggles.
- Output stage: a single register holding {tag, data} plus an occupied flag.
  - Loads from the FIFO head when the stage is empty, or when its current word is transferring this cycle (back-to-back, one word per cycle).
- Transfer: out_occ && lane_ready[sel]. Readiness on any other lane is ignored.
- Output mapping:
  - lane_valid = out_occ ? (4'b0001 << sel) : 4'b0000.
  - y = out_occ ? data : 0, so unselected and idle demux outputs stay 0.
  - sel holds its last value while idle.
- Latency: a word accepted into an empty block appears on lane_valid two edges after its accept edge (FIFO write, then stage load). Steady-state throughput is 1 word/clock when the addressed lane is always ready.
- Stall: while lane_ready[sel]=0, y, sel and lane_valid hold stable. The FIFO keeps filling until full.
- Order: strict FIFO order across all lanes. A stalled lane blocks all following words (head-of-line blocking).
- Simultaneous push and pop on a non-full, non-empty FIFO: level unchanged.
- Wrap-around: read and write pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished with one extra pointer bit.
- Flush has priority over a same-cycle accept or transfer; both are discarded.
- Reset mid-transfer: the held word is lost. No lane_valid is asserted until a new accept.
- A change of in_dest while in_valid=1 and in_ready=0 is allowed. The value present on the accept edge is the one used.

Test Plan:
- Single word, rr_mode=0: in_data=0xA5, in_dest=2, all lane_ready=1 → 2 edges later y=0xA5, sel=2, lane_valid=4'b0100 for exactly 1 cycle; then y=0, lane_valid=0.
- Round-robin: rr_mode=1, push 0x11,0x22,0x33,0x44,0x55 back-to-back, lanes ready → sel sequence 0,1,2,3,0; lane_valid 0001,0010,0100,1000,0001 on consecutive cycles.
- Backpressure/full: lane_ready=0, push 6 words, DEPTH=4 → first word held in the output stage, level=4, in_ready=0 after the 5th accept, 6th word not accepted; release lane_ready → all 5 words drain in order, then in_ready returns to 1.
- Head-of-line blocking: word 0x10 to lane 1 (lane_ready[1]=0), then word 0x20 to lane 3 (lane_ready[3]=1) → lane_valid stays 0010 and 0x20 does not appear until lane_ready[1]=1.
- Flush: 3 words queued plus 1 held, assert flush for 1 cycle together with in_valid → next cycle level=0, lane_valid=0, y=0; the word presented in the flush cycle is discarded.
- Async reset: drop rst_n mid-stream between clock edges → lane_valid=0, y=0, in_ready=0 immediately without a clock edge; after release, rr_cnt starts at 0 (first rr word goes to sel=0).

Source files
------------

// File: rtl/demux_dispatch_x4.sv
// Valid/ready word buffer feeding a 1-to-4 demux: a small FIFO, then one output
// stage that holds {tag, data} until the addressed lane accepts it.
module demux_dispatch_x4 #(
  parameter int BUS_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          rr_mode,
  input  logic [BUS_WIDTH-1:0]          in_data,
  input  logic [1:0]                    in_dest,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [BUS_WIDTH-1:0]          y,
  output logic [1:0]                    sel,
  output logic [3:0]                    lane_valid,
  input  logic [3:0]                    lane_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = BUS_WIDTH + 2;

  typedef logic [AW:0] ptr_t;

  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  ptr_t                 wr_ptr_q, wr_ptr_d;
  ptr_t                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           rr_cnt_q, rr_cnt_d;
  logic                 out_occ_q, out_occ_d;
  logic [1:0]           out_sel_q, out_sel_d;
  logic [BUS_WIDTH-1:0] out_data_q, out_data_d;

  logic                 full, empty, accept, xfer, load;
  logic [1:0]           in_tag;
  logic [EW-1:0]        head;

  // The extra pointer bit tells a full FIFO apart from an empty one.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready = rst_n & ~full;
  assign accept   = in_valid & in_ready & ~flush;
  assign in_tag   = rr_mode ? rr_cnt_q : in_dest;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign xfer     = out_occ_q & lane_ready[out_sel_q];
  assign load     = ~empty & (~out_occ_q | xfer);

  // NOTE: every _d gets its current value first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rr_cnt_d   = rr_cnt_q;
    out_occ_d  = out_occ_q;
    out_sel_d  = out_sel_q;
    out_data_d = out_data_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      rr_cnt_d   = '0;
      out_occ_d  = 1'b0;
      out_sel_d  = '0;
      out_data_d = '0;
    end else begin
      if (accept) begin
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
        if (rr_mode) rr_cnt_d = rr_cnt_q + 2'd1;
      end
      if (load) begin
        rd_ptr_d   = rd_ptr_q + ptr_t'(1);
        out_occ_d  = 1'b1;
        out_sel_d  = head[EW-1 -: 2];
        out_data_d = head[BUS_WIDTH-1:0];
      end else if (xfer) begin
        out_occ_d = 1'b0;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rr_cnt_q   <= '0;
      out_occ_q  <= 1'b0;
      out_sel_q  <= '0;
      out_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rr_cnt_q   <= rr_cnt_d;
      out_occ_q  <= out_occ_d;
      out_sel_q  <= out_sel_d;
      out_data_q <= out_data_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q[AW-1:0]] <= {in_tag, in_data};
  end

  assign level      = wr_ptr_q - rd_ptr_q;
  assign sel        = out_sel_q;
  assign y          = out_occ_q ? out_data_q : '0;
  assign lane_valid = out_occ_q ? (4'b0001 << out_sel_q) : 4'b0000;

endmodule

// File: tb/tb_demux_dispatch_x4.sv
// Self-checking bench for demux_dispatch_x4: vector table for single words, a
// scoreboard on every lane transfer, and hand-written multi-cycle sequences.
module tb_demux_dispatch_x4;

  logic       clk = 1'b0;
  logic       rst_n, flush, rr_mode, in_valid, in_ready;
  logic [7:0] in_data, y;
  logic [1:0] in_dest, sel;
  logic [3:0] lane_valid, lane_ready;
  logic [2:0] level;

  demux_dispatch_x4 #(.BUS_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .rr_mode(rr_mode),
    .in_data(in_data), .in_dest(in_dest), .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .sel(sel), .lane_valid(lane_valid), .lane_ready(lane_ready), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [1:0] dest;
    logic       rr;
    logic [1:0] exp_sel;
    logic [3:0] exp_lv;
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  logic [9:0] exp_q [$];
  logic [1:0] rr_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: observe accepts and lane transfers just before the edge that commits them.
  task automatic monitor_step();
    logic [9:0] e;
    if (!rst_n || flush) begin
      exp_q.delete();
      rr_m = 2'd0;
    end else begin
      if ((lane_valid & lane_ready) != 4'b0) begin
        check("sb_have_expected", 32'(exp_q.size() > 0), 32'h1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sb_sel", 32'(sel), 32'(e[9:8]));
          check("sb_y", 32'(y), 32'(e[7:0]));
          check("sb_lane_valid", 32'(lane_valid), 32'(4'b0001 << e[9:8]));
        end
      end
      if (lane_valid == 4'b0) check("idle_y_zero", 32'(y), 32'h0);
      if (in_valid && in_ready) begin
        exp_q.push_back({rr_mode ? rr_m : in_dest, in_data});
        if (rr_mode) rr_m = rr_m + 2'd1;
      end
    end
  endtask

  // Drives one word and returns just after the edge that accepted it.
  task automatic push_word(input logic [7:0] d, input logic [1:0] dst, input logic rr);
    int n;
    in_data = d; in_dest = dst; rr_mode = rr; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check("push_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    vec_t       vecs [6];
    logic [3:0] exp_rr [7];
    logic [3:0] lv_seen [7];
    int         n;

    vecs[0] = '{data: 8'hA5, dest: 2'd2, rr: 1'b0, exp_sel: 2'd2, exp_lv: 4'b0100};
    vecs[1] = '{data: 8'h3C, dest: 2'd0, rr: 1'b0, exp_sel: 2'd0, exp_lv: 4'b0001};
    vecs[2] = '{data: 8'hC3, dest: 2'd1, rr: 1'b0, exp_sel: 2'd1, exp_lv: 4'b0010};
    vecs[3] = '{data: 8'hFF, dest: 2'd3, rr: 1'b0, exp_sel: 2'd3, exp_lv: 4'b1000};
    vecs[4] = '{data: 8'h5A, dest: 2'd3, rr: 1'b1, exp_sel: 2'd0, exp_lv: 4'b0001};
    vecs[5] = '{data: 8'h66, dest: 2'd3, rr: 1'b1, exp_sel: 2'd1, exp_lv: 4'b0010};
    exp_rr  = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};

    rst_n = 1'b0; flush = 1'b0; rr_mode = 1'b0; in_valid = 1'b0;
    in_data = '0; in_dest = '0; lane_ready = 4'hF; rr_m = 2'd0;

    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    // Reset state
    step(); step();
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_lane_valid", 32'(lane_valid), 32'h0);
    check("rst_y", 32'(y), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 32'(in_ready), 32'h1);

    // Single words: two-edge latency, one-cycle strobe, sel held while idle
    foreach (vecs[i]) begin
      push_word(vecs[i].data, vecs[i].dest, vecs[i].rr);
      check("vec_not_yet", 32'(lane_valid), 32'h0);
      step();
      check("vec_y", 32'(y), 32'(vecs[i].data));
      check("vec_sel", 32'(sel), 32'(vecs[i].exp_sel));
      check("vec_lane_valid", 32'(lane_valid), 32'(vecs[i].exp_lv));
      step();
      check("vec_idle_lv", 32'(lane_valid), 32'h0);
      check("vec_idle_y", 32'(y), 32'h0);
      check("vec_sel_hold", 32'(sel), 32'(vecs[i].exp_sel));
    end

    // Round-robin from a cleared counter, back-to-back
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_word(8'h11 * (i + 1), 2'd3, 1'b1);
      lv_seen[i] = lane_valid;
    end
    step(); lv_seen[5] = lane_valid;
    step(); lv_seen[6] = lane_valid;
    for (int i = 0; i < 7; i++) check("rr_lane_seq", 32'(lv_seen[i]), 32'(exp_rr[i]));

    // Backpressure until full, then drain
    lane_ready = 4'h0;
    for (int i = 0; i < 5; i++) push_word(8'hB0 + 8'(i), 2'(i), 1'b0);
    check("bp_level_full", 32'(level), 32'h4);
    check("bp_not_ready", 32'(in_ready), 32'h0);
    check("bp_held_lv", 32'(lane_valid), 32'b0001);
    check("bp_held_y", 32'(y), 32'hB0);
    in_data = 8'hB5; in_dest = 2'd1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_sixth_blocked", 32'(in_ready), 32'h0);
      check("bp_level_hold", 32'(level), 32'h4);
    end
    in_valid = 1'b0;
    lane_ready = 4'hF;
    n = 0;
    do begin
      step();
      n++;
    end while ((lane_valid != 4'b0 || level != 3'd0) && n < 20);
    check("bp_drain_in_time", 32'(n < 20), 32'h1);
    check("bp_ready_again", 32'(in_ready), 32'h1);
    check("bp_all_drained", 32'(exp_q.size()), 32'h0);

    // Head-of-line blocking
    lane_ready = 4'b1101;
    push_word(8'h10, 2'd1, 1'b0);
    push_word(8'h20, 2'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("hol_lv", 32'(lane_valid), 32'b0010);
      check("hol_y", 32'(y), 32'h10);
      step();
    end
    lane_ready = 4'hF;
    step();
    check("hol_next_lv", 32'(lane_valid), 32'b1000);
    check("hol_next_y", 32'(y), 32'h20);
    step();
    check("hol_done", 32'(lane_valid), 32'h0);

    // Flush with three queued plus one held, and a word presented in the flush cycle
    lane_ready = 4'h0;
    for (int i = 0; i < 4; i++) push_word(8'hC0 + 8'(i), 2'd2, 1'b0);
    check("fl_level_before", 32'(level), 32'h3);
    check("fl_held_before", 32'(lane_valid), 32'b0100);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h99; in_dest = 2'd0; lane_ready = 4'hF;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_level", 32'(level), 32'h0);
    check("fl_lv", 32'(lane_valid), 32'h0);
    check("fl_y", 32'(y), 32'h0);
    check("fl_sel", 32'(sel), 32'h0);
    step(); step();
    check("fl_word_discarded", 32'(lane_valid), 32'h0);

    // Asynchronous reset mid-stream, then round-robin restarts at lane 0
    lane_ready = 4'h0;
    push_word(8'hD0, 2'd3, 1'b1);
    push_word(8'hD1, 2'd3, 1'b1);
    check("ar_held", 32'(lane_valid), 32'b0001);
    in_valid = 1'b1; in_data = 8'hD2;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_lv", 32'(lane_valid), 32'h0);
    check("ar_y", 32'(y), 32'h0);
    check("ar_in_ready", 32'(in_ready), 32'h0);
    check("ar_level", 32'(level), 32'h0);
    in_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    lane_ready = 4'hF;
    step();
    check("ar_still_idle", 32'(lane_valid), 32'h0);
    push_word(8'h77, 2'd3, 1'b1);
    step();
    check("ar_rr_sel", 32'(sel), 32'h0);
    check("ar_rr_lv", 32'(lane_valid), 32'b0001);
    check("ar_rr_y", 32'(y), 32'h77);
    step(); step();
    check("end_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
